fsk_bit_modulator: RTL and testbench

Serializes one Hamming codeword at a time and drives a two-tone FSK square wave, one tone per bit value. Sits directly downstream of the Hamming encoder and replaces the free-running divided-clock approach with in-clock-domain tone division. Everything runs on the system clock, with no derived clocks. The FSK output feeds the channel/PCM stage.

---
 rtl/fsk_bit_modulator.sv | 151 +++++++++++++++
 tb/tb_fsk_bit_modulator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_bit_modulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fsk_bit_modulator
// Description : Serializes one codeword per frame, MSB first, and emits a
//               two-tone FSK square wave. Both tones are divided down inside
//               the system clock domain, so no derived clocks are used.
// Revision    : 1.0 - initial release
// ============================================================================
module fsk_bit_modulator #(
  parameter int WIDTH      = 7,
  parameter int BIT_CYCLES = 16,
  parameter int HALF0      = 4,
  parameter int HALF1      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             fsk_out,
  output logic             bit_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             frame_done
);

  localparam int BCW  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HMAX = (HALF0 > HALF1) ? HALF0 : HALF1;
  // A phase counter for tones of half-period 1 still needs one bit to exist
  localparam int PHW  = (HMAX > 1) ? $clog2(HMAX) : 1;

  localparam logic [BCW-1:0] BC_LAST  = BCW'(BIT_CYCLES - 1);
  localparam logic [BIW-1:0] BI_LAST  = BIW'(WIDTH - 1);
  localparam logic [PHW-1:0] PH_LAST0 = PHW'(HALF0 - 1);
  localparam logic [PHW-1:0] PH_LAST1 = PHW'(HALF1 - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BCW-1:0]   bc_q, bc_d;
  logic [BIW-1:0]   bi_q, bi_d;
  logic [PHW-1:0]   ph_q, ph_d;
  logic             fsk_q, fsk_d;
  logic             bit_q, bit_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic [PHW-1:0]   ph_last;

  // Next-state logic: frame acceptance, bit sequencing and tone division
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bc_d     = bc_q;
    bi_d     = bi_q;
    ph_d     = ph_q;
    fsk_d    = fsk_q;
    bit_d    = bit_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    ph_last  = bit_q ? PH_LAST1 : PH_LAST0;

    case (state_q)
      S_IDLE: begin
        bc_d  = '0;
        bi_d  = '0;
        ph_d  = '0;
        fsk_d = 1'b0;
        bit_d = 1'b0;
        if (din_valid) begin
          state_d  = S_SEND;
          sr_d     = din;
          bit_d    = din[WIDTH-1];
          strobe_d = 1'b1;
        end
      end

      S_SEND: begin
        // Half-period reached: flip the tone
        if (ph_q == ph_last) begin
          ph_d  = '0;
          fsk_d = ~fsk_q;
        end else begin
          ph_d = ph_q + 1'b1;
        end

        if (bc_q == BC_LAST) begin
          // Bit boundary: the phase restarts but the level carries over,
          // so a toggle landing on this edge is kept
          bc_d = '0;
          ph_d = '0;
          if (bi_q == BI_LAST) begin
            state_d = S_IDLE;
            bi_d    = '0;
            done_d  = 1'b1;
            fsk_d   = 1'b0;
            bit_d   = 1'b0;
          end else begin
            bi_d     = bi_q + 1'b1;
            sr_d     = sr_q << 1;
            bit_d    = sr_q[WIDTH-2];
            strobe_d = 1'b1;
          end
        end else begin
          bc_d = bc_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      bc_q     <= '0;
      bi_q     <= '0;
      ph_q     <= '0;
      fsk_q    <= 1'b0;
      bit_q    <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bc_q     <= bc_d;
      bi_q     <= bi_d;
      ph_q     <= ph_d;
      fsk_q    <= fsk_d;
      bit_q    <= bit_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign din_ready  = (state_q == S_IDLE);
  assign busy       = (state_q == S_SEND);
  assign fsk_out    = fsk_q;
  assign bit_out    = bit_q;
  assign bit_strobe = strobe_q;
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fsk_bit_modulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fsk_bit_modulator
// Description : Directed bench for fsk_bit_modulator with a per-bit
//               scoreboard; one instance with default parameters and one
//               with the smallest bit/tone periods.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsk_bit_modulator;

  localparam int W   = 7;
  localparam int BC  = 16;
  localparam int H0  = 4;
  localparam int H1  = 2;
  localparam int BBC = 2;
  localparam int BH0 = 1;
  localparam int BH1 = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din, din_b;
  logic         din_valid, din_valid_b;
  logic         din_ready, fsk_out, bit_out, bit_strobe, busy, frame_done;
  logic         din_ready_b, fsk_out_b, bit_out_b, bit_strobe_b, busy_b, frame_done_b;

  fsk_bit_modulator #(.WIDTH(W), .BIT_CYCLES(BC), .HALF0(H0), .HALF1(H1)) u_dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .fsk_out(fsk_out), .bit_out(bit_out),
    .bit_strobe(bit_strobe), .busy(busy), .frame_done(frame_done)
  );

  fsk_bit_modulator #(.WIDTH(W), .BIT_CYCLES(BBC), .HALF0(BH0), .HALF1(BH1)) u_dut_b (
    .clk(clk), .reset(reset), .din(din_b), .din_valid(din_valid_b),
    .din_ready(din_ready_b), .fsk_out(fsk_out_b), .bit_out(bit_out_b),
    .bit_strobe(bit_strobe_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  always #5 clk = ~clk;

  // One scoreboard entry per transmitted bit
  typedef struct packed {
    logic b;    // bit value
    logic lvl;  // fsk level expected in the first cycle of the bit
    int   tog;  // fsk changes expected while the bit is on air
  } item_t;

  item_t sb0[$];
  item_t sb1[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc[2], tog[2], cur_tog[2], last_s[2], first_s[2], nstr[2], done_cnt[2];
  logic prev_fsk[2], in_bit[2];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected bits, tone levels and toggle counts for one frame
  task automatic push_frame(input int i, input int w, input int bc, input int h0,
                            input int h1, input logic [31:0] d);
    logic  lvl;
    item_t it;
    int    h, t;
    lvl = 1'b0;
    for (int k = 0; k < w; k++) begin
      it.b   = d[w-1-k];
      h      = it.b ? h1 : h0;
      t      = bc / h;
      it.lvl = lvl;
      // The final edge of a frame forces the tone low, so a toggle due on
      // that edge is not observable as a toggle
      it.tog = (k == w - 1 && (bc % h) == 0) ? t - 1 : t;
      lvl    = lvl ^ t[0];
      if (i == 0) sb0.push_back(it);
      else        sb1.push_back(it);
    end
  endtask

  task automatic mon_step(input int i, input int w, input int bc, input logic rst,
                          input logic strobe, input logic bo, input logic fsk,
                          input logic done, input logic bsy, input logic rdy);
    logic  chg;
    item_t it;
    int    depth;
    cyc[i]++;
    chg = (fsk !== prev_fsk[i]);
    if (rst) begin
      in_bit[i] = 1'b0;
      nstr[i]   = 0;
      tog[i]    = 0;
    end else if (done) begin
      check1("done_busy", bsy, 1'b0);
      check1("done_ready", rdy, 1'b1);
      check1("done_fsk", fsk, 1'b0);
      check1("done_bit", bo, 1'b0);
      check1("done_in_frame", in_bit[i], 1'b1);
      check("last_bit_toggles", tog[i], cur_tog[i]);
      check("strobes_per_frame", nstr[i], w);
      check("frame_len", cyc[i] - first_s[i], w * bc);
      done_cnt[i]++;
      in_bit[i] = 1'b0;
      nstr[i]   = 0;
      tog[i]    = 0;
    end else if (strobe) begin
      if (chg) tog[i]++;
      if (in_bit[i]) check("bit_toggles", tog[i], cur_tog[i]);
      if (nstr[i] > 0) check("strobe_gap", cyc[i] - last_s[i], bc);
      else             first_s[i] = cyc[i];
      depth = (i == 0) ? sb0.size() : sb1.size();
      if (depth == 0) begin
        check("sb_depth_at_strobe", depth, 1);
        cur_tog[i] = 0;
      end else begin
        it = (i == 0) ? sb0.pop_front() : sb1.pop_front();
        check1("bit_out", bo, it.b);
        check1("fsk_level_at_bit_start", fsk, it.lvl);
        cur_tog[i] = it.tog;
      end
      check1("busy_in_send", bsy, 1'b1);
      check1("ready_in_send", rdy, 1'b0);
      tog[i]    = 0;
      in_bit[i] = 1'b1;
      last_s[i] = cyc[i];
      nstr[i]++;
    end else begin
      if (chg) tog[i]++;
    end
    prev_fsk[i] = fsk;
  endtask

  // Output monitors, sampled on the falling edge
  always @(negedge clk)
    mon_step(0, W, BC, reset, bit_strobe, bit_out, fsk_out, frame_done, busy, din_ready);

  always @(negedge clk)
    mon_step(1, W, BBC, reset, bit_strobe_b, bit_out_b, fsk_out_b, frame_done_b, busy_b, din_ready_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input int limit, output int n);
    logic d;
    n = 0;
    d = (i == 0) ? frame_done : frame_done_b;
    while (n < limit && d !== 1'b1) begin
      tick();
      n++;
      d = (i == 0) ? frame_done : frame_done_b;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    din         = 7'h55;
    din_valid   = 1'b1;
    din_b       = '0;
    din_valid_b = 1'b0;

    // Reset held with din_valid high
    for (int k = 0; k < 3; k++) begin
      tick();
      check1("rst_ready", din_ready, 1'b1);
      check1("rst_busy", busy, 1'b0);
      check1("rst_fsk", fsk_out, 1'b0);
      check1("rst_bit", bit_out, 1'b0);
      check1("rst_strobe", bit_strobe, 1'b0);
      check1("rst_done", frame_done, 1'b0);
    end
    reset     = 1'b0;
    din_valid = 1'b0;
    tick();
    check1("idle_busy", busy, 1'b0);
    check1("idle_ready", din_ready, 1'b1);

    // Single frame
    din       = 7'b1011001;
    din_valid = 1'b1;
    push_frame(0, W, BC, H0, H1, 32'(din));
    tick();
    din_valid = 1'b0;
    check1("acc_busy", busy, 1'b1);
    check1("acc_strobe", bit_strobe, 1'b1);
    check1("acc_bit", bit_out, 1'b1);
    check1("acc_ready", din_ready, 1'b0);
    wait_done(0, 200, n);
    check("frame_done_latency", n, W * BC);
    check1("fd_ready", din_ready, 1'b1);
    check1("fd_busy", busy, 1'b0);
    tick();
    check1("fd_single_pulse", frame_done, 1'b0);
    check1("idle_after_frame", busy, 1'b0);

    // Inputs ignored while sending
    din       = 7'b1100101;
    din_valid = 1'b1;
    push_frame(0, W, BC, H0, H1, 32'(din));
    tick();
    for (int k = 0; k < 100; k++) begin
      din       = 7'($urandom_range(127, 0));
      din_valid = k[0];
      tick();
      check1("ready_low_while_busy", din_ready, 1'b0);
    end
    din_valid = 1'b0;
    wait_done(0, 200, n);
    check("frame_done_latency_busy_inputs", n, W * BC - 100);
    tick();

    // Back-to-back frames with din_valid held high
    din       = 7'h7F;
    din_valid = 1'b1;
    push_frame(0, W, BC, H0, H1, 32'h7F);
    push_frame(0, W, BC, H0, H1, 32'h00);
    tick();
    check1("b2b_acc1_strobe", bit_strobe, 1'b1);
    din = 7'h00;
    wait_done(0, 200, n);
    check("b2b_frame1_len", n, W * BC);
    check1("b2b_ready_at_done", din_ready, 1'b1);
    tick();
    check1("b2b_acc2_busy", busy, 1'b1);
    check1("b2b_acc2_strobe", bit_strobe, 1'b1);
    check1("b2b_acc2_bit", bit_out, 1'b0);
    din_valid = 1'b0;
    wait_done(0, 200, n);
    check("b2b_frame2_len", n, W * BC);
    tick();

    // Reset in the middle of a frame
    din       = 7'b1010101;
    din_valid = 1'b1;
    push_frame(0, W, BC, H0, H1, 32'(din));
    tick();
    din_valid = 1'b0;
    repeat (39) tick();
    reset = 1'b1;
    sb0.delete();
    tick();
    check1("abort_ready", din_ready, 1'b1);
    check1("abort_busy", busy, 1'b0);
    check1("abort_fsk", fsk_out, 1'b0);
    check1("abort_bit", bit_out, 1'b0);
    check1("abort_strobe", bit_strobe, 1'b0);
    check1("abort_no_done", frame_done, 1'b0);
    reset     = 1'b0;
    din       = 7'b0110011;
    din_valid = 1'b1;
    push_frame(0, W, BC, H0, H1, 32'(din));
    tick();
    din_valid = 1'b0;
    check1("post_abort_accept", busy, 1'b1);
    check1("post_abort_bit", bit_out, 1'b0);
    wait_done(0, 200, n);
    check("post_abort_frame_len", n, W * BC);
    tick();

    // Smallest bit period, tone half-periods 1 and 2
    din_b       = 7'b0101010;
    din_valid_b = 1'b1;
    push_frame(1, W, BBC, BH0, BH1, 32'(din_b));
    tick();
    din_valid_b = 1'b0;
    check1("b_acc_strobe", bit_strobe_b, 1'b1);
    check1("b_acc_bit", bit_out_b, 1'b0);
    wait_done(1, 50, n);
    check("b_frame_len", n, W * BBC);
    tick();
    tick();

    check("frames_done_default", done_cnt[0], 5);
    check("frames_done_boundary", done_cnt[1], 1);
    check("sb0_leftover", sb0.size(), 0);
    check("sb1_leftover", sb1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
